icache_mshr_table: RTL and testbench

ICACHE_MSHR_TABLE -- requirements
Module: icache_mshr_table

---
 rtl/icache_mshr_table.sv | 168 ++++++++++++++++
 tb/tb_icache_mshr_table.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_mshr_table.sv
// Instruction-cache miss status holding table.
// Tracks outstanding block misses, merges later misses to the same block,
// issues one refill request per block to L2 and wakes the waiting warps
// when the refill completes.
module icache_mshr_table #(
    parameter int  NUM_ENTRY   = 4,
    parameter int  ENTRY_DEPTH = 2,
    parameter int  BLK_ADDR_W  = 26,
    parameter int  NUM_WARP    = 8,
    localparam int WID_W       = $clog2(NUM_WARP)
) (
    input  logic                   clk,
    input  logic                   rst,
    // miss from tag stage
    input  logic                   miss_req_valid_i,
    output logic                   miss_req_ready_o,
    input  logic [BLK_ADDR_W-1:0]  miss_req_addr_i,
    input  logic [WID_W-1:0]       miss_req_wid_i,
    // refill request to L2
    output logic                   mem_req_valid_o,
    input  logic                   mem_req_ready_i,
    output logic [BLK_ADDR_W-1:0]  mem_req_addr_o,
    output logic [ENTRY_DEPTH-1:0] mem_req_tag_o,
    // refill completion
    input  logic                   mem_rsp_valid_i,
    output logic                   mem_rsp_ready_o,
    input  logic [ENTRY_DEPTH-1:0] mem_rsp_tag_i,
    // wakeup to warp scheduler
    output logic                   refill_valid_o,
    output logic [BLK_ADDR_W-1:0]  refill_addr_o,
    output logic [NUM_WARP-1:0]    refill_warp_mask_o,
    // occupancy
    output logic                   full_o,
    output logic [ENTRY_DEPTH:0]   pending_cnt_o
);

    localparam int CNT_W = ENTRY_DEPTH + 1;

    logic [NUM_ENTRY-1:0]  valid_q, valid_d;
    logic [NUM_ENTRY-1:0]  sent_q, sent_d;
    logic [BLK_ADDR_W-1:0] addr_q [NUM_ENTRY];
    logic [BLK_ADDR_W-1:0] addr_d [NUM_ENTRY];
    logic [NUM_WARP-1:0]   mask_q [NUM_ENTRY];
    logic [NUM_WARP-1:0]   mask_d [NUM_ENTRY];

    logic                  refill_valid_q, refill_valid_d;
    logic [BLK_ADDR_W-1:0] refill_addr_q, refill_addr_d;
    logic [NUM_WARP-1:0]   refill_mask_q, refill_mask_d;

    logic [NUM_ENTRY-1:0]   rsp_sel;     // entry being freed by a response this cycle
    logic [NUM_ENTRY-1:0]   match_vec;
    logic [NUM_WARP-1:0]    wid_onehot;
    logic                   match;
    logic [ENTRY_DEPTH-1:0] match_idx;
    logic [ENTRY_DEPTH-1:0] free_idx;
    logic [ENTRY_DEPTH-1:0] send_idx;
    logic                   send_found;
    logic                   accept;
    logic [CNT_W-1:0]       cnt;

    // Per-entry response decode and address match; out-of-range tags select nothing.
    // An entry being freed is excluded from matching so a merge can never be lost.
    for (genvar gi = 0; gi < NUM_ENTRY; gi++) begin : g_entry
        assign rsp_sel[gi]   = mem_rsp_valid_i && (mem_rsp_tag_i == ENTRY_DEPTH'(gi))
                               && valid_q[gi] && sent_q[gi];
        assign match_vec[gi] = valid_q[gi] && !rsp_sel[gi] && (addr_q[gi] == miss_req_addr_i);
    end

    assign wid_onehot = NUM_WARP'(1) << miss_req_wid_i;
    assign match      = |match_vec;
    assign full_o     = &valid_q;

    // Priority lookups: matching entry, lowest free entry, lowest unsent entry, occupancy
    always_comb begin
        match_idx  = '0;
        free_idx   = '0;
        send_idx   = '0;
        send_found = 1'b0;
        cnt        = '0;
        for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
            if (match_vec[i]) match_idx = ENTRY_DEPTH'(i);
            if (!valid_q[i])  free_idx  = ENTRY_DEPTH'(i);
            if (valid_q[i] && !sent_q[i]) begin
                send_idx   = ENTRY_DEPTH'(i);
                send_found = 1'b1;
            end
        end
        for (int i = 0; i < NUM_ENTRY; i++) begin
            cnt = cnt + CNT_W'(valid_q[i]);
        end
    end

    assign miss_req_ready_o   = match || !full_o;
    assign accept             = miss_req_valid_i && miss_req_ready_o;
    assign mem_req_valid_o    = send_found;
    assign mem_req_tag_o      = send_idx;
    assign mem_req_addr_o     = addr_q[send_idx];
    assign mem_rsp_ready_o    = 1'b1;
    assign pending_cnt_o      = cnt;
    assign refill_valid_o     = refill_valid_q;
    assign refill_addr_o      = refill_addr_q;
    assign refill_warp_mask_o = refill_mask_q;

    // Next-state: send, free, merge and allocate all apply in the same cycle
    always_comb begin
        valid_d        = valid_q;
        sent_d         = sent_q;
        addr_d         = addr_q;
        mask_d         = mask_q;
        refill_valid_d = |rsp_sel;
        refill_addr_d  = refill_addr_q;
        refill_mask_d  = refill_mask_q;

        if (mem_req_valid_o && mem_req_ready_i) begin
            sent_d[send_idx] = 1'b1;
        end

        for (int i = 0; i < NUM_ENTRY; i++) begin
            if (rsp_sel[i]) begin
                refill_addr_d = addr_q[i];
                refill_mask_d = mask_q[i];
            end
        end
        valid_d = valid_d & ~rsp_sel;
        sent_d  = sent_d & ~rsp_sel;

        // A freed entry is not allocatable until next cycle: free_idx uses valid_q
        if (accept) begin
            if (match) begin
                mask_d[match_idx] = mask_q[match_idx] | wid_onehot;
            end else begin
                valid_d[free_idx] = 1'b1;
                sent_d[free_idx]  = 1'b0;
                addr_d[free_idx]  = miss_req_addr_i;
                mask_d[free_idx]  = wid_onehot;
            end
        end
    end

    // Control state and warp masks, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q        <= '0;
            sent_q         <= '0;
            refill_valid_q <= 1'b0;
            for (int i = 0; i < NUM_ENTRY; i++) begin
                mask_q[i] <= '0;
            end
        end else begin
            valid_q        <= valid_d;
            sent_q         <= sent_d;
            refill_valid_q <= refill_valid_d;
            for (int i = 0; i < NUM_ENTRY; i++) begin
                mask_q[i] <= mask_d[i];
            end
        end
    end

    // Address and refill payload registers carry no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ENTRY; i++) begin
            addr_q[i] <= addr_d[i];
        end
        refill_addr_q <= refill_addr_d;
        refill_mask_q <= refill_mask_d;
    end

endmodule

// File: tb/tb_icache_mshr_table.sv
// Directed bench for icache_mshr_table: expected refills are queued when a
// response is driven and compared when the refill pulse appears.
module tb_icache_mshr_table;

    localparam int NUM_ENTRY   = 4;
    localparam int ENTRY_DEPTH = 2;
    localparam int BLK_ADDR_W  = 26;
    localparam int NUM_WARP    = 8;
    localparam int WID_W       = 3;

    typedef struct packed {
        logic [BLK_ADDR_W-1:0] addr;
        logic [NUM_WARP-1:0]   mask;
    } refill_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   miss_req_valid_i;
    logic                   miss_req_ready_o;
    logic [BLK_ADDR_W-1:0]  miss_req_addr_i;
    logic [WID_W-1:0]       miss_req_wid_i;
    logic                   mem_req_valid_o;
    logic                   mem_req_ready_i;
    logic [BLK_ADDR_W-1:0]  mem_req_addr_o;
    logic [ENTRY_DEPTH-1:0] mem_req_tag_o;
    logic                   mem_rsp_valid_i;
    logic                   mem_rsp_ready_o;
    logic [ENTRY_DEPTH-1:0] mem_rsp_tag_i;
    logic                   refill_valid_o;
    logic [BLK_ADDR_W-1:0]  refill_addr_o;
    logic [NUM_WARP-1:0]    refill_warp_mask_o;
    logic                   full_o;
    logic [ENTRY_DEPTH:0]   pending_cnt_o;

    int      checks = 0;
    int      errors = 0;
    refill_t sb_q[$];

    icache_mshr_table #(
        .NUM_ENTRY  (NUM_ENTRY),
        .ENTRY_DEPTH(ENTRY_DEPTH),
        .BLK_ADDR_W (BLK_ADDR_W),
        .NUM_WARP   (NUM_WARP)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_req_valid_i  (miss_req_valid_i),
        .miss_req_ready_o  (miss_req_ready_o),
        .miss_req_addr_i   (miss_req_addr_i),
        .miss_req_wid_i    (miss_req_wid_i),
        .mem_req_valid_o   (mem_req_valid_o),
        .mem_req_ready_i   (mem_req_ready_i),
        .mem_req_addr_o    (mem_req_addr_o),
        .mem_req_tag_o     (mem_req_tag_o),
        .mem_rsp_valid_i   (mem_rsp_valid_i),
        .mem_rsp_ready_o   (mem_rsp_ready_o),
        .mem_rsp_tag_i     (mem_rsp_tag_i),
        .refill_valid_o    (refill_valid_o),
        .refill_addr_o     (refill_addr_o),
        .refill_warp_mask_o(refill_warp_mask_o),
        .full_o            (full_o),
        .pending_cnt_o     (pending_cnt_o)
    );

    always #5 clk = ~clk;

    // Refill monitor: every pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (refill_valid_o === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $error("FAIL unexpected_refill: observed addr 0x%0h mask 0x%0h, required no refill",
                       refill_addr_o, refill_warp_mask_o);
            end else begin
                refill_t exp_r;
                exp_r = sb_q.pop_front();
                assert ({refill_addr_o, refill_warp_mask_o} === exp_r) else begin
                    errors++;
                    $error("FAIL refill: observed addr 0x%0h mask 0x%0h, required addr 0x%0h mask 0x%0h",
                           refill_addr_o, refill_warp_mask_o, exp_r.addr, exp_r.mask);
                end
                $display("refill addr 0x%0h mask 0x%0h", refill_addr_o, refill_warp_mask_o);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic miss(input logic [BLK_ADDR_W-1:0] a, input logic [WID_W-1:0] w);
        miss_req_valid_i = 1'b1;
        miss_req_addr_i  = a;
        miss_req_wid_i   = w;
        $display("miss addr 0x%0h wid %0d", a, w);
    endtask

    task automatic rsp(input logic [ENTRY_DEPTH-1:0] t, input logic expect_refill,
                       input logic [BLK_ADDR_W-1:0] a, input logic [NUM_WARP-1:0] m);
        refill_t r;
        mem_rsp_valid_i = 1'b1;
        mem_rsp_tag_i   = t;
        if (expect_refill) begin
            r.addr = a;
            r.mask = m;
            sb_q.push_back(r);
        end
        $display("rsp tag %0d", t);
    endtask

    initial begin
        rst              = 1'b1;
        miss_req_valid_i = 1'b0;
        miss_req_addr_i  = '0;
        miss_req_wid_i   = '0;
        mem_req_ready_i  = 1'b0;
        mem_rsp_valid_i  = 1'b0;
        mem_rsp_tag_i    = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_pending", 32'(pending_cnt_o), 32'd0);
        chk("rst_full", 32'(full_o), 32'd0);
        chk("rst_ready", 32'(miss_req_ready_o), 32'd1);
        chk("rst_memvalid", 32'(mem_req_valid_o), 32'd0);
        chk("rst_refill", 32'(refill_valid_o), 32'd0);
        chk("rsp_ready", 32'(mem_rsp_ready_o), 32'd1);

        // Single miss, request, response
        mem_req_ready_i = 1'b1;
        miss(26'h100, 3'd2);
        #1;
        chk("m1_ready", 32'(miss_req_ready_o), 32'd1);
        chk("m1_no_send_same_cycle", 32'(mem_req_valid_o), 32'd0);
        tick();
        miss_req_valid_i = 1'b0;
        #1;
        chk("m1_memvalid", 32'(mem_req_valid_o), 32'd1);
        chk("m1_tag", 32'(mem_req_tag_o), 32'd0);
        chk("m1_addr", 32'(mem_req_addr_o), 32'h100);
        chk("m1_pending", 32'(pending_cnt_o), 32'd1);
        tick();
        chk("m1_sent", 32'(mem_req_valid_o), 32'd0);
        rsp(2'd0, 1'b1, 26'h100, 8'h04);
        tick();
        mem_rsp_valid_i = 1'b0;
        #1;
        chk("m1_pending_after", 32'(pending_cnt_o), 32'd0);
        tick();

        // Merge two warps into one request
        mem_req_ready_i = 1'b0;
        miss(26'h100, 3'd2);
        tick();
        miss(26'h100, 3'd5);
        #1;
        chk("merge_ready", 32'(miss_req_ready_o), 32'd1);
        tick();
        miss_req_valid_i = 1'b0;
        #1;
        chk("merge_pending", 32'(pending_cnt_o), 32'd1);
        mem_req_ready_i = 1'b1;
        #1;
        chk("merge_tag", 32'(mem_req_tag_o), 32'd0);
        tick();
        mem_req_ready_i = 1'b0;
        #1;
        chk("merge_single_req", 32'(mem_req_valid_o), 32'd0);
        rsp(2'd0, 1'b1, 26'h100, 8'h24);
        tick();
        mem_rsp_valid_i = 1'b0;
        tick();

        // Fill the table
        for (int k = 0; k < 4; k++) begin
            miss(26'h10 + 26'(k), 3'd0);
            tick();
        end
        miss(26'h20, 3'd0);
        #1;
        chk("full_flag", 32'(full_o), 32'd1);
        chk("full_pending", 32'(pending_cnt_o), 32'd4);
        chk("full_stall", 32'(miss_req_ready_o), 32'd0);
        tick();
        miss(26'h11, 3'd7);
        #1;
        chk("full_merge_ready", 32'(miss_req_ready_o), 32'd1);
        tick();
        miss_req_valid_i = 1'b0;
        #1;
        chk("full_merge_pending", 32'(pending_cnt_o), 32'd4);

        // Back-pressure on memory request: payload holds
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(mem_req_valid_o), 32'd1);
            chk("bp_tag", 32'(mem_req_tag_o), 32'd0);
            chk("bp_addr", 32'(mem_req_addr_o), 32'h10);
            tick();
        end
        mem_req_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("send_order", 32'(mem_req_tag_o), 32'(k));
            tick();
        end
        mem_req_ready_i = 1'b0;
        #1;
        chk("all_sent", 32'(mem_req_valid_o), 32'd0);

        // Response frees entry 1 while a new miss waits on a full table
        rsp(2'd1, 1'b1, 26'h11, 8'h81);
        miss(26'h20, 3'd0);
        #1;
        chk("free_same_cycle_stall", 32'(miss_req_ready_o), 32'd0);
        tick();
        mem_rsp_valid_i = 1'b0;
        #1;
        chk("free_next_ready", 32'(miss_req_ready_o), 32'd1);
        chk("free_next_full", 32'(full_o), 32'd0);
        tick();
        miss_req_valid_i = 1'b0;
        #1;
        chk("realloc_full", 32'(full_o), 32'd1);
        chk("realloc_tag", 32'(mem_req_tag_o), 32'd1);
        chk("realloc_addr", 32'(mem_req_addr_o), 32'h20);
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        rsp(2'd0, 1'b1, 26'h10, 8'h01);
        tick();
        rsp(2'd2, 1'b1, 26'h12, 8'h01);
        tick();
        rsp(2'd3, 1'b1, 26'h13, 8'h01);
        tick();
        rsp(2'd1, 1'b1, 26'h20, 8'h01);
        tick();
        mem_rsp_valid_i = 1'b0;
        #1;
        chk("drain_pending", 32'(pending_cnt_o), 32'd0);
        tick();

        // Stale response to an invalid entry is ignored
        rsp(2'd3, 1'b0, '0, '0);
        tick();
        mem_rsp_valid_i = 1'b0;
        #1;
        chk("stale_no_refill", 32'(refill_valid_o), 32'd0);
        tick();

        // Response and same-address miss together: miss allocates a fresh entry
        mem_req_ready_i = 1'b1;
        miss(26'h40, 3'd1);
        tick();
        miss_req_valid_i = 1'b0;
        tick();
        rsp(2'd0, 1'b1, 26'h40, 8'h02);
        miss(26'h40, 3'd3);
        #1;
        chk("race_ready", 32'(miss_req_ready_o), 32'd1);
        tick();
        mem_rsp_valid_i  = 1'b0;
        miss_req_valid_i = 1'b0;
        #1;
        chk("race_new_valid", 32'(mem_req_valid_o), 32'd1);
        chk("race_new_tag", 32'(mem_req_tag_o), 32'd1);
        chk("race_new_addr", 32'(mem_req_addr_o), 32'h40);
        tick();
        rsp(2'd1, 1'b1, 26'h40, 8'h08);
        tick();
        mem_rsp_valid_i = 1'b0;
        tick();
        chk("race_pending", 32'(pending_cnt_o), 32'd0);

        // Reset with three misses outstanding
        miss(26'h50, 3'd0);
        tick();
        miss(26'h51, 3'd1);
        tick();
        miss(26'h52, 3'd2);
        tick();
        miss_req_valid_i = 1'b0;
        tick();
        tick();
        chk("pre_rst_pending", 32'(pending_cnt_o), 32'd3);
        chk("pre_rst_sent", 32'(mem_req_valid_o), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_pending", 32'(pending_cnt_o), 32'd0);
        chk("mid_rst_ready", 32'(miss_req_ready_o), 32'd1);
        chk("mid_rst_memvalid", 32'(mem_req_valid_o), 32'd0);
        chk("mid_rst_full", 32'(full_o), 32'd0);
        rsp(2'd0, 1'b0, '0, '0);
        tick();
        mem_rsp_valid_i = 1'b0;
        #1;
        chk("post_rst_no_refill", 32'(refill_valid_o), 32'd0);
        tick();
        tick();

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
